// File: rtl/mem_pkg.sv
// Shared memory-bus constants and responder state type.
// Defaults here match the processor core's bus declarations.
package mem_pkg;

  localparam int unsigned MEM_WIDTH    = 32;
  localparam int unsigned MEM_ADDRSIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Memory bus: valid/ready request channel (initiator -> target) and
// valid/ready read-response channel (target -> initiator), plus sticky error.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int width    = MEM_WIDTH,
  parameter int addrsize = MEM_ADDRSIZE
);

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [addrsize-1:0] req_addr;
  logic [width-1:0]    req_wdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [width-1:0]    rsp_rdata;
  logic                rsp_err;

  logic                err_sticky;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky
  );

endinterface

// File: rtl/mem_responder_sp_ram.sv
// Single-port synchronous RAM, one write enable, registered read output (1 cycle).
// No flow control; storage array is never reset.
module sp_ram #(
  parameter int width = 32,
  parameter int depth = 256,
  parameter int aw    = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    addr,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-bus target: writes commit in 1 cycle, reads respond 2 edges after accept.
// One read outstanding; response held stable under rsp_ready backpressure.
module mem_responder
  import mem_pkg::*;
#(
  parameter int width    = MEM_WIDTH,
  parameter int addrsize = MEM_ADDRSIZE,
  parameter int memsize  = 1 << addrsize
) (
  input  logic            clk,
  input  logic            nrst,
  mem_responder_if.slave  bus
);

  localparam int aw = (memsize > 1) ? $clog2(memsize) : 1;
  // One extra bit so memsize == 2**addrsize is representable.
  localparam logic [addrsize:0] mem_limit = (addrsize + 1)'(memsize);

  mem_state_t       state;
  mem_state_t       state_nxt;

  logic [aw-1:0]    addr_q;
  logic             pend_err;
  logic             rsp_valid_q;
  logic [width-1:0] rsp_rdata_q;
  logic             rsp_err_q;
  logic             err_sticky_q;

  logic             req_ready_c;
  logic             req_in_range;
  logic             wr_acc;
  logic             rd_acc;
  logic             ram_we;
  logic [aw-1:0]    ram_addr;
  logic [width-1:0] ram_rdata;
  logic             load_rsp;
  logic             rsp_done;

  assign req_ready_c = nrst && (state == IDLE);

  always_comb begin
    state_nxt    = state;
    req_in_range = ({1'b0, bus.req_addr} < mem_limit);
    wr_acc       = bus.req_valid && req_ready_c && bus.req_we;
    rd_acc       = bus.req_valid && req_ready_c && !bus.req_we;
    ram_we       = wr_acc && req_in_range;
    ram_addr     = addr_q;
    load_rsp     = 1'b0;
    rsp_done     = 1'b0;

    case (state)
      IDLE: begin
        ram_addr = bus.req_addr[aw-1:0];
        if (rd_acc) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
      end
      RESP: begin
        // First RESP cycle captures the RAM's registered output into the response.
        if (!rsp_valid_q) begin
          load_rsp = 1'b1;
        end else if (bus.rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr_q       <= '0;
      pend_err     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if ((wr_acc || rd_acc) && !req_in_range) begin
        err_sticky_q <= 1'b1;
      end
      if (rd_acc) begin
        addr_q   <= bus.req_addr[aw-1:0];
        pend_err <= !req_in_range;
      end
      if (load_rsp) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= pend_err ? '0 : ram_rdata;
        rsp_err_q   <= pend_err;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  sp_ram #(
    .width (width),
    .depth (memsize),
    .aw    (aw)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.req_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder (memsize=200): directed scenarios plus random traffic
// checked against a word-level memory model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int W  = 32;
  localparam int AS = 8;
  localparam int MS = 200;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.width(W), .addrsize(AS)) bus ();

  mem_responder #(.width(W), .addrsize(AS), .memsize(MS)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] model_mem [int];
  bit           model_sticky;

  function automatic void model_write(input logic [AS-1:0] a, input logic [W-1:0] d);
    if (int'(a) < MS) model_mem[int'(a)] = d;
    else model_sticky = 1'b1;
  endfunction

  function automatic logic [W-1:0] model_rdata(input logic [AS-1:0] a);
    if (int'(a) >= MS) return '0;
    if (!model_mem.exists(int'(a))) return 'x;
    return model_mem[int'(a)];
  endfunction

  task automatic do_write(input logic [AS-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    model_write(a, d);
  endtask

  // Returns at the negedge where rsp_valid is first seen; consumes it if rsp_ready is high.
  task automatic do_read(input logic [AS-1:0] a, output logic [W-1:0] d,
                         output logic e, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    d = bus.rsp_rdata;
    e = bus.rsp_err;
    if (int'(a) >= MS) model_sticky = 1'b1;
    if (bus.rsp_ready === 1'b1) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
    n_tests++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky got %b want 0", bus.err_sticky); end
    nrst = 1'b1;
    model_sticky = 1'b0;
    #1;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write_read();
    logic [W-1:0] d; logic e; int lat;
    do_write(8'h05, 32'hDEADBEEF);
    do_read(8'h05, d, e, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL wr_rd_latency got %0d want 2", lat); end
    n_tests++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data got %h want deadbeef", d); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_rd_err got %b want 0", e); end
    n_tests++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL wr_rd_sticky got %b want 0", bus.err_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d; logic e; int lat;
    logic [AS-1:0] rd_addrs [2];
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1;
      bus.req_addr = AS'(i); bus.req_wdata = W'(i * 3);
      #1;
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.req_ready); end
      model_write(AS'(i), W'(i * 3));
      @(negedge clk);
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    rd_addrs[0] = 8'h07; rd_addrs[1] = 8'h0F;
    for (int k = 0; k < 2; k++) begin
      do_read(rd_addrs[k], d, e, lat);
      n_tests++; if (d !== model_rdata(rd_addrs[k])) begin n_fail++; $display("FAIL b2b_read[%h] got %h want %h", rd_addrs[k], d, model_rdata(rd_addrs[k])); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d, exp_d, wv; logic e; int lat;
    exp_d = model_rdata(8'h05);
    wv = $urandom;
    bus.rsp_ready = 1'b0;
    do_read(8'h05, d, e, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got %0d want 2", lat); end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h30; bus.req_wdata = wv;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_d || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b want 1 %h 0",
                 c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, exp_d);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    model_write(8'h30, wv);
    do_read(8'h30, d, e, lat);
    n_tests++; if (d !== wv) begin n_fail++; $display("FAIL bp_pending_write got %h want %h", d, wv); end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] d, v; logic e; int lat;
    do_write(8'hC8, 32'h11);
    n_tests++; if (bus.err_sticky !== 1'b1) begin n_fail++; $display("FAIL oor_sticky got %b want 1", bus.err_sticky); end
    do_read(8'hC8, d, e, lat);
    n_tests++; if (e !== 1'b1 || d !== '0) begin n_fail++; $display("FAIL oor_read got err=%b data=%h want 1 0", e, d); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL oor_latency got %0d want 2", lat); end
    v = $urandom;
    do_write(8'hC7, v);
    do_read(8'hC7, d, e, lat);
    n_tests++; if (e !== 1'b0 || d !== v) begin n_fail++; $display("FAIL top_word got err=%b data=%h want 0 %h", e, d, v); end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] d, v; logic e; int lat;
    v = $urandom;
    do_write(8'h20, v);
    bus.rsp_ready = 1'b0;
    do_read(8'h20, d, e, lat);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    model_sticky = 1'b0;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", bus.rsp_valid); end
    n_tests++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL midreset_sticky got %b want 0", bus.err_sticky); end
    bus.rsp_ready = 1'b1;
    do_read(8'h20, d, e, lat);
    n_tests++; if (d !== v) begin n_fail++; $display("FAIL midreset_ram_kept got %h want %h", d, v); end
  endtask

  task automatic test_raw();
    int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h10; bus.req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    model_write(8'h10, 32'hA5A5A5A5);
    bus.req_we = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    n_tests++; if (bus.rsp_rdata !== model_rdata(8'h10) || lat !== 2) begin n_fail++; $display("FAIL raw got data=%h lat=%0d want %h 2", bus.rsp_rdata, lat, model_rdata(8'h10)); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] d, exp_d; logic e, exp_e; int lat, hold;
    logic [AS-1:0] a;
    for (int it = 0; it < 60; it++) begin
      a = AS'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0 || (int'(a) < MS && !model_mem.exists(int'(a)))) begin
        do_write(a, $urandom);
      end else begin
        exp_d = model_rdata(a);
        exp_e = (int'(a) >= MS);
        hold = $urandom_range(0, 3);
        bus.rsp_ready = (hold == 0);
        do_read(a, d, e, lat);
        n_tests++;
        if (d !== exp_d || e !== exp_e || lat !== 2) begin
          n_fail++;
          $display("FAIL rand_read[%h] got data=%h err=%b lat=%0d want %h %b 2", a, d, e, lat, exp_d, exp_e);
        end
        if (hold != 0) begin
          repeat (hold) @(negedge clk);
          n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_d) begin n_fail++; $display("FAIL rand_hold[%h] got valid=%b data=%h want 1 %h", a, bus.rsp_valid, bus.rsp_rdata, exp_d); end
          bus.rsp_ready = 1'b1;
          @(negedge clk);
        end
      end
    end
    #1;
    n_tests++; if (bus.err_sticky !== model_sticky) begin n_fail++; $display("FAIL rand_sticky got %b want %b", bus.err_sticky, model_sticky); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    model_sticky  = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_op();
    test_raw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
